// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program counter (pc_sequencer).
// The optional return-address stack is enabled with the PC_RAS_EN macro.
package pc_pkg;

    localparam int unsigned WORD_SIZE_DEF    = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0080;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } pc_state_e;

    // Mask that clears the low log2(instr_bytes) bits; instr_bytes is a power of two.
    function automatic logic [63:0] align_mask(input int unsigned instr_bytes);
        align_mask = ~(64'(instr_bytes) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest entry,
// and a simultaneous push/pop replaces the top entry in place.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [WORD_SIZE-1:0] i_data,
    output logic [WORD_SIZE-1:0] o_top,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WORD_SIZE-1:0] r_mem [DEPTH];
    logic [PW-1:0]        r_ptr;
    logic [CW-1:0]        r_cnt;
    logic [PW-1:0]        w_ptr_inc;
    logic [PW-1:0]        w_ptr_dec;

    assign w_ptr_inc = (r_ptr == PW'(DEPTH - 1)) ? {PW{1'b0}} : r_ptr + PW'(1);
    assign w_ptr_dec = (r_ptr == {PW{1'b0}}) ? PW'(DEPTH - 1) : r_ptr - PW'(1);

    assign o_top   = r_mem[w_ptr_dec];
    assign o_empty = (r_cnt == {CW{1'b0}});
    assign o_full  = (r_cnt == CW'(DEPTH));

    // Stack storage, write pointer and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= {PW{1'b0}};
            r_cnt <= {CW{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= {WORD_SIZE{1'b0}};
            end
        end else begin
            if (i_push && i_pop) begin
                r_mem[w_ptr_dec] <= i_data;
            end else if (i_push) begin
                r_mem[r_ptr] <= i_data;
                r_ptr        <= w_ptr_inc;
                if (!o_full) begin
                    r_cnt <= r_cnt + CW'(1);
                end else begin
                    r_cnt <= r_cnt;
                end
            end else if (i_pop) begin
                r_ptr <= w_ptr_dec;
                r_cnt <= r_cnt - CW'(1);
            end else begin
                r_ptr <= r_ptr;
                r_cnt <= r_cnt;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with BOOT/RUN/HALT sequencing and a saturating fetch count.
// Define PC_RAS_EN to add the call/return stack (pc_ras).
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned          WORD_SIZE    = WORD_SIZE_DEF,
    parameter int unsigned          INSTR_BYTES  = 4,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = WORD_SIZE'(RESET_VECTOR_DEF),
    parameter logic [WORD_SIZE-1:0] EXC_VECTOR   = WORD_SIZE'(EXC_VECTOR_DEF),
    parameter int unsigned          CNT_WIDTH    = 16,
    parameter int unsigned          RAS_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    input  logic                 fetch_ready_i,
    input  logic                 redirect_i,
    input  logic [WORD_SIZE-1:0] redirect_pc_i,
    input  logic                 exc_i,
    input  logic                 halt_i,
    input  logic                 resume_i,
    input  logic                 call_i,
    input  logic                 ret_i,
    output logic [WORD_SIZE-1:0] pc_o,
    output logic                 pc_valid_o,
    output logic [WORD_SIZE-1:0] epc_o,
    output logic                 misalign_o,
    output logic [CNT_WIDTH-1:0] fetch_cnt_o
);

    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = WORD_SIZE'(align_mask(INSTR_BYTES));
    localparam logic [WORD_SIZE-1:0] PC_STEP    = WORD_SIZE'(INSTR_BYTES);

    pc_state_e            r_state;
    logic [WORD_SIZE-1:0] r_pc;
    logic                 r_valid;
    logic [WORD_SIZE-1:0] r_epc;
    logic                 r_misalign;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic                 w_accept;
    logic                 w_run;
    logic [WORD_SIZE-1:0] w_pc_seq;
    logic [WORD_SIZE-1:0] w_redir_pc;
    logic                 w_redir_mis;
    logic                 w_ret_take;
    logic [WORD_SIZE-1:0] w_ras_top;

    assign w_run       = (r_state == ST_RUN);
    assign w_accept    = r_valid & fetch_ready_i & ~stall_i;
    assign w_pc_seq    = r_pc + PC_STEP;
    assign w_redir_pc  = redirect_pc_i & ALIGN_MASK;
    assign w_redir_mis = |(redirect_pc_i & ~ALIGN_MASK);

`ifdef PC_RAS_EN
    logic w_push;
    logic w_pop;
    logic w_ras_empty;
    logic w_ras_full_unused;

    // A return only pops when it wins priority, or when it pairs with a call (pop then push).
    assign w_push     = w_run & ~exc_i & redirect_i & call_i;
    assign w_pop      = w_run & ~exc_i & ret_i & ~w_ras_empty & (~redirect_i | call_i);
    assign w_ret_take = w_run & ~exc_i & ~redirect_i & ret_i & ~w_ras_empty;

    pc_ras #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_seq),
        .o_top   (w_ras_top),
        .o_full  (w_ras_full_unused),
        .o_empty (w_ras_empty)
    );
`else
    logic w_unused;

    assign w_ret_take = 1'b0;
    assign w_ras_top  = {WORD_SIZE{1'b0}};
    assign w_unused   = &{1'b0, call_i, ret_i, RAS_DEPTH[0]};
`endif

    // Sequencer FSM with registered PC, fetch-valid, EPC and misalign pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VECTOR;
            r_valid    <= 1'b0;
            r_epc      <= {WORD_SIZE{1'b0}};
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                    r_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (exc_i) begin
                        r_pc  <= EXC_VECTOR;
                        r_epc <= r_pc;
                    end else if (redirect_i) begin
                        r_pc       <= w_redir_pc;
                        r_misalign <= w_redir_mis;
                    end else if (w_ret_take) begin
                        r_pc <= w_ras_top;
                    end else if (halt_i) begin
                        r_state <= ST_HALT;
                        r_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_pc <= w_pc_seq;
                    end else begin
                        r_pc <= r_pc;
                    end
                end
                ST_HALT: begin
                    if (exc_i) begin
                        r_state <= ST_RUN;
                        r_valid <= 1'b1;
                        r_pc    <= EXC_VECTOR;
                        r_epc   <= r_pc;
                    end else if (resume_i) begin
                        r_state <= ST_RUN;
                        r_valid <= 1'b1;
                    end else begin
                        r_state <= ST_HALT;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of accepted fetches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= {CNT_WIDTH{1'b0}};
        end else if (w_accept && (r_cnt != {CNT_WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign pc_o        = r_pc;
    assign pc_valid_o  = r_valid;
    assign epc_o       = r_epc;
    assign misalign_o  = r_misalign;
    assign fetch_cnt_o = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random traffic against a
// queue-based reference model. Return-stack checks are active when PC_RAS_EN is defined.
module tb_pc_sequencer;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0, fetch_ready_i = 1'b0, redirect_i = 1'b0, exc_i = 1'b0;
    logic        halt_i = 1'b0, resume_i = 1'b0, call_i = 1'b0, ret_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic [31:0] pc_o, epc_o;
    logic        pc_valid_o, misalign_o;
    logic [CW-1:0] fetch_cnt_o;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0]   m_pc, m_epc;
    logic          m_mis;
    logic [CW-1:0] m_cnt;
    bit            m_boot, m_halt;
    logic [31:0]   m_stack[$];
    logic [31:0]   old_pc;

    pc_sequencer #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .fetch_ready_i(fetch_ready_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .exc_i(exc_i),
        .halt_i(halt_i), .resume_i(resume_i), .call_i(call_i), .ret_i(ret_i),
        .pc_o(pc_o), .pc_valid_o(pc_valid_o), .epc_o(epc_o), .misalign_o(misalign_o),
        .fetch_cnt_o(fetch_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("pc", pc_o, m_pc);
        chk("valid", {31'd0, pc_valid_o}, {31'd0, (!m_boot && !m_halt)});
        chk("epc", epc_o, m_epc);
        chk("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
        chk("fetch_cnt", {28'd0, fetch_cnt_o}, {28'd0, m_cnt});
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_epc = 32'h0; m_mis = 1'b0; m_cnt = '0;
        m_boot = 1'b1; m_halt = 1'b0;
        m_stack.delete();
    endtask

    task automatic model_step();
        bit ras;
`ifdef PC_RAS_EN
        ras = 1'b1;
`else
        ras = 1'b0;
`endif
        m_mis = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halt) begin
            if (exc_i) begin
                m_epc = m_pc; m_pc = 32'h80; m_halt = 1'b0;
            end else if (resume_i) begin
                m_halt = 1'b0;
            end
        end else begin
            if (fetch_ready_i && !stall_i && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
            if (exc_i) begin
                m_epc = m_pc; m_pc = 32'h80;
            end else if (redirect_i) begin
                if (ras && call_i) begin
                    if (ret_i && m_stack.size() > 0) void'(m_stack.pop_back());
                    m_stack.push_back(m_pc + 32'd4);
                    if (m_stack.size() > 4) void'(m_stack.pop_front());
                end
                m_mis = (redirect_pc_i % 32'd4) != 32'd0;
                m_pc  = redirect_pc_i - (redirect_pc_i % 32'd4);
            end else if (ras && ret_i && m_stack.size() > 0) begin
                m_pc = m_stack.pop_back();
            end else if (halt_i) begin
                m_halt = 1'b1;
            end else if (fetch_ready_i && !stall_i) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic clr_in();
        stall_i = 1'b0; fetch_ready_i = 1'b1; redirect_i = 1'b0; exc_i = 1'b0;
        halt_i = 1'b0; resume_i = 1'b0; call_i = 1'b0; ret_i = 1'b0;
        redirect_pc_i = 32'h0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_i = 1'b1; redirect_pc_i = target;
        cyc();
        clr_in();
    endtask

    initial begin
        clr_in();
        model_reset();
        #12;
        check_all();
        rst = 1'b0;
        #1;
        check_all();

        // boot cycle then sequential 0,4,8,12
        repeat (4) cyc();
        chk("seq_pc12", pc_o, 32'd12);
        chk("seq_cnt3", {28'd0, fetch_cnt_o}, 32'd3);

        // stall holds PC and count
        cyc();
        stall_i = 1'b1;
        repeat (3) cyc();
        chk("stall_pc", pc_o, 32'h10);
        stall_i = 1'b0;
        cyc();
        chk("stall_release", pc_o, 32'h14);

        // misaligned redirect, then exception beating a redirect
        redirect_i = 1'b1; redirect_pc_i = 32'h103;
        cyc();
        chk("redir_pc", pc_o, 32'h100);
        chk("redir_mis", {31'd0, misalign_o}, 32'd1);
        clr_in();
        cyc();
        old_pc = pc_o;
        exc_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200;
        cyc();
        chk("exc_pc", pc_o, 32'h80);
        chk("exc_epc", epc_o, old_pc);
        clr_in();

        // halt at 0x20, hold, resume
        redirect_to(32'h20);
        halt_i = 1'b1;
        cyc();
        clr_in();
        repeat (5) cyc();
        chk("halt_valid", {31'd0, pc_valid_o}, 32'd0);
        resume_i = 1'b1;
        cyc();
        clr_in();
        cyc();
        chk("resume_pc", pc_o, 32'h24);

        // reset in the middle of HALT
        halt_i = 1'b1;
        cyc();
        clr_in();
        repeat (2) cyc();
        do_reset();
        chk("rst_halt_pc", pc_o, 32'h0);
        repeat (3) cyc();

        // wrap at the top of the address space, then counter saturation
        redirect_to(32'hFFFF_FFFC);
        cyc();
        chk("wrap_pc", pc_o, 32'h0);
        repeat (20) cyc();
        chk("cnt_sat", {28'd0, fetch_cnt_o}, 32'hF);

`ifdef PC_RAS_EN
        // call/return pair, then overflow of the four-entry stack
        redirect_to(32'h40);
        redirect_i = 1'b1; call_i = 1'b1; redirect_pc_i = 32'h200;
        cyc();
        clr_in();
        ret_i = 1'b1;
        cyc();
        clr_in();
        chk("ras_ret", pc_o, 32'h44);
        for (int k = 0; k < 5; k++) begin
            redirect_i = 1'b1; call_i = 1'b1; redirect_pc_i = 32'h1000 * (k + 1);
            cyc();
        end
        clr_in();
        for (int k = 0; k < 5; k++) begin
            old_pc = pc_o;
            ret_i = 1'b1;
            cyc();
        end
        chk("ras_empty_step", pc_o, old_pc + 32'd4);
        clr_in();
`endif

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            stall_i       = ($urandom % 4) == 0;
            fetch_ready_i = ($urandom % 4) != 0;
            exc_i         = ($urandom % 20) == 0;
            redirect_i    = ($urandom % 7) == 0;
            halt_i        = ($urandom % 15) == 0;
            resume_i      = ($urandom % 4) == 0;
            call_i        = ($urandom % 2) == 0;
            ret_i         = ($urandom % 6) == 0;
            redirect_pc_i = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            cyc();
            if (n == 300) begin
                clr_in();
                do_reset();
            end
        end
        clr_in();
        do_reset();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
